u_rec_fifo: RTL and testbench

Receive-side byte buffer that sits directly downstream of the UART receiver. It watches the receiver's `rec_readyH` / `rec_dataH` outputs and turns each completed frame into one FIFO entry. False-start glitches are rejected by measuring how long `rec_readyH` stays low. The captured bytes are presented to the host side as a show-ahead FIFO with full/empty/count and a sticky overrun flag.

---
 rtl/u_rec_fifo.sv | 149 ++++++++++++++
 tb/tb_u_rec_fifo.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/u_rec_fifo.sv
// rtl/u_rec_fifo.sv - receive-side byte FIFO fed by the UART receiver ready/data outputs
// Frames whose ready-low time is too short are rejected as runts; good frames are queued show-ahead.
module u_rec_fifo #(
    parameter int ADDR_W  = 4,
    parameter int MIN_LOW = 64
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [7:0]        rec_dataH,
    input  logic              rec_readyH,
    input  logic              rd_enH,
    output logic [7:0]        fifo_dataH,
    output logic              fifo_emptyH,
    output logic              fifo_fullH,
    output logic [ADDR_W:0]   fifo_countH,
    output logic              overrunH,
    input  logic              clr_overrunH,
    output logic              runtH
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = $clog2(MIN_LOW + 1);
    localparam logic [CNT_W-1:0]  MIN_LOW_C = CNT_W'(MIN_LOW);
    localparam logic [CNT_W-1:0]  ONE_C     = CNT_W'(1);
    localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE_C = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE_C = ADDR_W'(1);

    typedef enum logic [1:0] {
        ST_ARM  = 2'd0,
        ST_IDLE = 2'd1,
        ST_BUSY = 2'd2
    } state_t;

    state_t            state_q;
    logic              ready_q;
    logic [CNT_W-1:0]  low_cnt_q;
    logic              runt_q;

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overrun_q, overrun_d;

    logic              rise;
    logic              low_long;
    logic              push_req;
    logic              empty, full;
    logic              pop_ok, push_ok, ovr_set;

    assign rise     = rec_readyH & ~ready_q;
    assign low_long = (low_cnt_q >= MIN_LOW_C);
    // Push is decided in the rising-edge cycle itself so the write lands at the end of that cycle.
    assign push_req = (state_q == ST_BUSY) & rise & low_long;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q   <= ST_ARM;
            ready_q   <= 1'b0;
            low_cnt_q <= '0;
            runt_q    <= 1'b0;
        end else begin
            ready_q <= rec_readyH;
            runt_q  <= 1'b0;
            case (state_q)
                ST_ARM: begin
                    if (rec_readyH) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (!rec_readyH) begin
                        state_q   <= ST_BUSY;
                        low_cnt_q <= ONE_C;
                    end
                end
                ST_BUSY: begin
                    if (!rec_readyH) begin
                        if (!low_long) begin
                            low_cnt_q <= low_cnt_q + ONE_C;
                        end
                    end else if (rise) begin
                        state_q <= ST_IDLE;
                        runt_q  <= ~low_long;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_ARM;
                end
            endcase
        end
    end

    assign empty   = (count_q == '0);
    assign full    = (count_q == DEPTH_C);
    assign pop_ok  = rd_enH & ~empty;
    // When full, a simultaneous pop frees the slot the push needs.
    assign push_ok = push_req & (~full | pop_ok);
    assign ovr_set = push_req & full & ~pop_ok;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = ovr_set | (overrun_q & ~clr_overrunH);
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE_C;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE_C;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE_C;
            2'b01:   count_d = count_q - CNT_ONE_C;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= rec_dataH;
        end
    end

    assign fifo_dataH  = empty ? 8'h00 : mem[rd_ptr_q];
    assign fifo_emptyH = empty;
    assign fifo_fullH  = full;
    assign fifo_countH = count_q;
    assign overrunH    = overrun_q;
    assign runtH       = runt_q;

endmodule

// File: tb/tb_u_rec_fifo.sv
// tb/tb_u_rec_fifo.sv - randomized and directed bench for u_rec_fifo against a queue-based model
module tb_u_rec_fifo;

    localparam int ADDR_W  = 4;
    localparam int MIN_LOW = 64;
    localparam int DEPTH   = 1 << ADDR_W;

    logic              sys_clk = 1'b0;
    logic              sys_rst;
    logic [7:0]        rec_dataH;
    logic              rec_readyH;
    logic              rd_enH;
    logic              clr_overrunH;
    logic [7:0]        fifo_dataH;
    logic              fifo_emptyH;
    logic              fifo_fullH;
    logic [ADDR_W:0]   fifo_countH;
    logic              overrunH;
    logic              runtH;

    int vectors    = 0;
    int miscompares = 0;
    int runt_seen  = 0;
    bit rnd        = 1'b0;
    int pop_div    = 4;

    u_rec_fifo #(.ADDR_W(ADDR_W), .MIN_LOW(MIN_LOW)) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .rec_dataH    (rec_dataH),
        .rec_readyH   (rec_readyH),
        .rd_enH       (rd_enH),
        .fifo_dataH   (fifo_dataH),
        .fifo_emptyH  (fifo_emptyH),
        .fifo_fullH   (fifo_fullH),
        .fifo_countH  (fifo_countH),
        .overrunH     (overrunH),
        .clr_overrunH (clr_overrunH),
        .runtH        (runtH)
    );

    always #5 sys_clk = ~sys_clk;

    // Behavioural model: length of the current low run decides accept/reject.
    bit               armed, prev_r, m_ov, m_runt;
    int               low_len;
    logic [7:0]       q[$];
    bit               m_push, m_runt_n, m_pop, m_ovs;

    always @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            armed = 0; prev_r = 0; low_len = 0; m_ov = 0; m_runt = 0;
            q.delete();
        end else begin
            m_push = 0; m_runt_n = 0;
            if (!armed) begin
                if (rec_readyH) armed = 1;
            end else if (!rec_readyH) begin
                if (low_len < 100000) low_len = low_len + 1;
            end else begin
                if (!prev_r && low_len > 0) begin
                    if (low_len >= MIN_LOW) m_push = 1;
                    else m_runt_n = 1;
                end
                low_len = 0;
            end
            m_pop = rd_enH && q.size() > 0;
            m_ovs = m_push && q.size() == DEPTH && !m_pop;
            if (m_pop) void'(q.pop_front());
            if (m_push && !m_ovs) q.push_back(rec_dataH);
            m_ov   = m_ovs || (m_ov && !clr_overrunH);
            m_runt = m_runt_n;
            prev_r = rec_readyH;
        end
    end

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge sys_clk) begin
        lit("data",    32'(fifo_dataH),  32'(q.size() > 0 ? q[0] : 8'h00));
        lit("empty",   32'(fifo_emptyH), 32'(q.size() == 0));
        lit("full",    32'(fifo_fullH),  32'(q.size() == DEPTH));
        lit("count",   32'(fifo_countH), 32'(q.size()));
        lit("overrun", 32'(overrunH),    32'(m_ov));
        lit("runt",    32'(runtH),       32'(m_runt));
        if (runtH) runt_seen++;
    end

    task automatic step();
        @(posedge sys_clk);
        #1;
        if (rnd) begin
            rd_enH       = ($urandom_range(0, pop_div - 1) == 0);
            clr_overrunH = ($urandom_range(0, 31) == 0);
        end
    endtask

    task automatic frame(input int low, input logic [7:0] d, input bit pop_cap = 1'b0);
        rec_readyH = 1'b0;
        rec_dataH  = 8'($urandom);
        repeat (low) step();
        rec_readyH = 1'b1;
        rec_dataH  = d;
        if (pop_cap) rd_enH = 1'b1;
        step();
        if (pop_cap) rd_enH = 1'b0;
        repeat (3) step();
    endtask

    task automatic pop_chk(input string nm, input logic [7:0] exp);
        lit(nm, 32'(fifo_dataH), 32'(exp));
        rd_enH = 1'b1;
        step();
        rd_enH = 1'b0;
    endtask

    int r0;

    initial begin
        sys_rst = 1'b1; rec_readyH = 1'b0; rec_dataH = 8'h00; rd_enH = 1'b0; clr_overrunH = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        lit("rst_empty", 32'(fifo_emptyH), 32'd1);
        lit("rst_count", 32'(fifo_countH), 32'd0);
        lit("rst_data",  32'(fifo_dataH),  32'h00);
        sys_rst = 1'b0;

        // Post-reset 0->1 is absorbed
        repeat (4) step();
        rec_dataH = 8'hFF; rec_readyH = 1'b1;
        repeat (4) step();
        lit("arm_empty", 32'(fifo_emptyH), 32'd1);
        lit("arm_runt",  32'(runt_seen),   32'd0);

        frame(150, 8'hA5); frame(150, 8'h3C); frame(150, 8'h00);
        lit("three_count", 32'(fifo_countH), 32'd3);
        lit("model_three", 32'(q.size()),    32'd3);
        pop_chk("pop_a5", 8'hA5); pop_chk("pop_3c", 8'h3C); pop_chk("pop_00", 8'h00);
        lit("three_empty", 32'(fifo_emptyH), 32'd1);

        r0 = runt_seen;
        frame(5, 8'h55);
        lit("glitch_runt",  32'(runt_seen - r0), 32'd1);
        lit("glitch_count", 32'(fifo_countH),    32'd0);
        frame(150, 8'h12);
        pop_chk("after_glitch", 8'h12);

        frame(MIN_LOW - 1, 8'h63);
        lit("min_minus1", 32'(fifo_countH), 32'd0);
        frame(MIN_LOW, 8'h64);
        lit("min_exact", 32'(fifo_countH), 32'd1);
        pop_chk("pop_min", 8'h64);

        for (int i = 0; i < 17; i++) frame(150, 8'(i));
        lit("fill_full",  32'(fifo_fullH),  32'd1);
        lit("fill_count", 32'(fifo_countH), 32'd16);
        lit("fill_ovr",   32'(overrunH),    32'd1);
        lit("model_ovr",  32'(m_ov),        32'd1);
        for (int i = 0; i < 16; i++) pop_chk("fill_pop", 8'(i));
        clr_overrunH = 1'b1; step(); clr_overrunH = 1'b0;
        lit("ovr_clr", 32'(overrunH), 32'd0);

        for (int i = 0; i < 3; i++) frame(150, 8'hB0 + 8'(i));
        for (int i = 0; i < 3; i++) pop_chk("offset_pop", 8'hB0 + 8'(i));
        for (int i = 0; i < 16; i++) frame(150, 8'h20 + 8'(i));
        frame(150, 8'h77, 1'b1);
        lit("fullpop_count", 32'(fifo_countH), 32'd16);
        lit("fullpop_ovr",   32'(overrunH),    32'd0);
        for (int i = 1; i < 16; i++) pop_chk("wrap_pop", 8'h20 + 8'(i));
        pop_chk("last_77", 8'h77);
        lit("wrap_empty", 32'(fifo_emptyH), 32'd1);

        for (int i = 0; i < 5; i++) frame(150, 8'h40 + 8'(i));
        lit("pre_rst_count", 32'(fifo_countH), 32'd5);
        rec_readyH = 1'b0;
        repeat (30) step();
        sys_rst = 1'b1;
        step();
        lit("mid_rst_count", 32'(fifo_countH), 32'd0);
        lit("mid_rst_empty", 32'(fifo_emptyH), 32'd1);
        lit("mid_rst_data",  32'(fifo_dataH),  32'h00);
        sys_rst = 1'b0;
        repeat (100) step();
        rec_dataH = 8'h5A; rec_readyH = 1'b1;
        repeat (4) step();
        lit("rearm_ignored", 32'(fifo_countH), 32'd0);
        frame(150, 8'h99);
        pop_chk("rearm_pop", 8'h99);

        rnd = 1'b1;
        for (int i = 0; i < 120; i++) begin
            int len;
            pop_div = (i < 60) ? 64 : 4;
            case ($urandom_range(0, 3))
                0:       len = $urandom_range(1, 8);
                1:       len = $urandom_range(MIN_LOW - 4, MIN_LOW + 4);
                2:       len = 150;
                default: len = $urandom_range(MIN_LOW, 200);
            endcase
            frame(len, 8'($urandom));
        end
        rnd = 1'b0; clr_overrunH = 1'b0; rd_enH = 1'b1;
        repeat (20) step();
        rd_enH = 1'b0;
        step();
        lit("drain_empty", 32'(fifo_emptyH), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
